// File: rtl/lcr580_io.sv
// LCR580 I/O block: keyboard latch, border/mask registers, periodic timer and
// two-source level-sensitive interrupt controller with iff1-falling-edge acknowledge.
module lcr580_io #(
    parameter int TIMER_PERIOD = 500000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] address,
    input  logic [7:0]  out,
    input  logic        port_rd,
    input  logic        port_we,
    input  logic        iff1,
    input  logic [7:0]  kdata,
    input  logic        kdone,
    output logic        irq,
    output logic [3:0]  vector,
    output logic [7:0]  pin,
    output logic [2:0]  border
);

    localparam int CW = (TIMER_PERIOD > 2) ? $clog2(TIMER_PERIOD) : 1;

    logic [7:0]    port;
    logic [1:0]    mask;
    logic [7:0]    kbd_data;
    logic          kready;
    logic          tpend;
    logic          kpend;
    logic [CW-1:0] tcnt;
    logic          iff1_q;

    logic          wr_mask;
    logic          wr_border;
    logic          rd_kbd;
    logic          wrap;
    logic          ack;
    logic          tpend_nxt;
    logic          kpend_nxt;
    logic          unused_bits;

    assign port        = address[7:0];
    assign unused_bits = ^{address[15:8], out[7:3]};

    assign wr_mask   = port_we && (port == 8'h02);
    assign wr_border = port_we && (port == 8'hFE);
    assign rd_kbd    = port_rd && (port == 8'h00);
    assign wrap      = (tcnt == CW'(TIMER_PERIOD - 1));
    assign ack       = iff1_q && !iff1 && (vector != 4'd0);

    always_comb begin
        pin = 8'hFF;
        case (port)
            8'h00:   pin = kbd_data;
            8'h01:   pin = {7'b0, kready};
            8'h02:   pin = {6'b0, mask};
            8'hFE:   pin = {5'b0, border};
            default: pin = 8'hFF;
        endcase
    end

    always_comb begin
        vector = 4'd0;
        if (tpend)
            vector = 4'd1;
        else if (kpend)
            vector = 4'd2;
    end

    assign irq = iff1 && (tpend || kpend);

    // Mask clear beats a new event; a new event beats its own acknowledge.
    always_comb begin
        tpend_nxt = tpend;
        if (wr_mask && !out[0])
            tpend_nxt = 1'b0;
        else if (wrap && mask[0])
            tpend_nxt = 1'b1;
        else if (ack && tpend)
            tpend_nxt = 1'b0;
    end

    always_comb begin
        kpend_nxt = kpend;
        if (wr_mask && !out[1])
            kpend_nxt = 1'b0;
        else if (kdone && mask[1])
            kpend_nxt = 1'b1;
        else if (ack && !tpend)
            kpend_nxt = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset_n) begin
            border   <= 3'd0;
            mask     <= 2'd0;
            kbd_data <= 8'd0;
            kready   <= 1'b0;
            tpend    <= 1'b0;
            kpend    <= 1'b0;
            tcnt     <= '0;
            iff1_q   <= 1'b0;
        end else begin
            iff1_q <= iff1;
            tpend  <= tpend_nxt;
            kpend  <= kpend_nxt;
            tcnt   <= wrap ? '0 : tcnt + 1'b1;
            if (wr_border)
                border <= out[2:0];
            if (wr_mask)
                mask <= out[1:0];
            if (kdone) begin
                kbd_data <= kdata;
                kready   <= 1'b1;
            end else if (rd_kbd) begin
                kready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lcr580_io.sv
// Bench for lcr580_io: directed scenarios plus random traffic, all cycles checked
// by a queue-based scoreboard against a behavioural model of the port/interrupt rules.
module tb_lcr580_io;

    localparam int TP = 10;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] address = 16'h0000;
    logic [7:0]  out = 8'h00;
    logic        port_rd = 1'b0;
    logic        port_we = 1'b0;
    logic        iff1 = 1'b0;
    logic [7:0]  kdata = 8'h00;
    logic        kdone = 1'b0;
    logic        irq;
    logic [3:0]  vector;
    logic [7:0]  pin;
    logic [2:0]  border;

    lcr580_io #(.TIMER_PERIOD(TP)) dut (
        .clock(clock), .reset_n(reset_n), .address(address), .out(out),
        .port_rd(port_rd), .port_we(port_we), .iff1(iff1), .kdata(kdata),
        .kdone(kdone), .irq(irq), .vector(vector), .pin(pin), .border(border)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    endtask

    // Behavioural model state
    logic [2:0] m_border;
    logic [1:0] m_mask;
    logic [7:0] m_kbd;
    bit         m_kready, m_tpend, m_kpend, m_iffq;
    int         m_tcnt;

    typedef struct {
        logic [7:0] pin;
        logic       irq;
        logic [3:0] vector;
        logic [2:0] border;
    } exp_t;

    exp_t sb_q[$];
    bit   sb_on = 1'b0;

    function automatic int model_vector();
        if (m_tpend) return 1;
        if (m_kpend) return 2;
        return 0;
    endfunction

    function automatic exp_t model_outputs(input logic [7:0] p, input bit i1);
        exp_t e;
        case (p)
            8'h00:   e.pin = m_kbd;
            8'h01:   e.pin = {7'b0, m_kready};
            8'h02:   e.pin = {6'b0, m_mask};
            8'hFE:   e.pin = {5'b0, m_border};
            default: e.pin = 8'hFF;
        endcase
        e.vector = 4'(model_vector());
        e.irq    = i1 && (m_tpend || m_kpend);
        e.border = m_border;
        return e;
    endfunction

    task automatic model_step(input bit rst, input logic [7:0] p, input logic [7:0] d,
                              input bit rd, input bit we, input bit i1,
                              input logic [7:0] kd, input bit kv);
        int  acked;
        bit  t, k, tick;
        if (rst) begin
            m_border = 0; m_mask = 0; m_kbd = 0; m_kready = 0;
            m_tpend = 0; m_kpend = 0; m_tcnt = 0; m_iffq = 0;
            return;
        end
        acked  = (m_iffq && !i1) ? model_vector() : 0;
        tick   = (m_tcnt == TP - 1);
        m_tcnt = (m_tcnt + 1) % TP;
        // later assignments override earlier ones
        t = m_tpend; k = m_kpend;
        if (acked == 1) t = 0;
        if (acked == 2) k = 0;
        if (tick && m_mask[0]) t = 1;
        if (kv && m_mask[1]) k = 1;
        if (we && p == 8'h02 && !d[0]) t = 0;
        if (we && p == 8'h02 && !d[1]) k = 0;
        m_tpend = t; m_kpend = k;
        if (we && p == 8'h02) m_mask = d[1:0];
        if (we && p == 8'hFE) m_border = d[2:0];
        if (rd && p == 8'h00) m_kready = 0;
        if (kv) begin m_kbd = kd; m_kready = 1; end
        m_iffq = i1;
    endtask

    // One clock: capture inputs, push expected outputs, advance model at the edge.
    task automatic cycle();
        bit rst, rd, we, i1, kv;
        logic [7:0] p, d, kd;
        rst = reset_n; p = address[7:0]; d = out; rd = port_rd; we = port_we;
        i1 = iff1; kd = kdata; kv = kdone;
        if (sb_on) sb_q.push_back(model_outputs(p, i1));
        @(posedge clock);
        model_step(rst, p, d, rd, we, i1, kd, kv);
        if (rst) sb_on = 1'b1;
        #1;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_pin", pin, e.pin);
            chk("sb_irq", irq, e.irq);
            chk("sb_vector", vector, e.vector);
            chk("sb_border", border, e.border);
        end
    end

    task automatic idle();
        port_rd = 0; port_we = 0; kdone = 0;
    endtask

    // Assumes a reset edge just occurred; enables the timer and measures irq latency.
    task automatic timer_latency(input string tag);
        int found = 0;
        iff1 = 1; port_we = 1; address = 16'h0002; out = 8'h01;
        cycle();
        idle();
        if (irq) found = 1;
        for (int k = 2; k <= 20; k++) begin
            cycle();
            if (irq && found == 0) found = k;
        end
        chk(tag, found, 10);
        chk({tag, "_vec"}, vector, 1);
    endtask

    initial begin
        int found;
        // Timer
        reset_n = 1; cycle(); reset_n = 0;
        timer_latency("timer_latency");
        iff1 = 0; cycle();
        chk("timer_ack_vector", vector, 0);
        chk("timer_ack_irq", irq, 0);

        // Border
        port_we = 1; address = 16'h12FE; out = 8'h05; cycle(); idle();
        chk("border_reg", border, 5);
        address = 16'h00FE; #1 chk("border_read", pin, 8'h05);
        address = 16'h3A7F; #1 chk("other_read", pin, 8'hFF);
        cycle();

        // Keyboard
        iff1 = 1; port_we = 1; address = 16'h0002; out = 8'h02; cycle(); idle();
        kdata = 8'h1C; kdone = 1; cycle(); idle();
        address = 16'h0001; #1 chk("kbd_status", pin, 8'h01);
        chk("kbd_irq", irq, 1);
        chk("kbd_vector", vector, 2);
        address = 16'h0000; port_rd = 1; #1 chk("kbd_data", pin, 8'h1C);
        cycle(); idle();
        address = 16'h0001; #1 chk("kbd_status_clr", pin, 8'h00);
        cycle();

        // Simultaneous kdone + data read
        address = 16'h0000; port_rd = 1; kdone = 1; kdata = 8'hA5; cycle(); idle();
        address = 16'h0001; #1 chk("simul_kready", pin, 8'h01);
        address = 16'h0000; #1 chk("simul_data", pin, 8'hA5);
        cycle();

        // Priority: kpend already set; enable timer and wait for it
        port_we = 1; address = 16'h0002; out = 8'h03; cycle(); idle();
        found = 0;
        for (int k = 0; k < 12 && found == 0; k++) begin
            cycle();
            if (vector == 4'd1) found = 1;
        end
        chk("prio_timer_seen", found, 1);
        iff1 = 0; cycle();
        chk("prio_after_ack", vector, 2);
        chk("prio_irq_low", irq, 0);
        iff1 = 1; #1 chk("prio_irq_again", irq, 1);
        cycle();

        // Reset mid-operation with strobes
        reset_n = 1; port_we = 1; address = 16'h00FE; out = 8'h07; kdone = 1;
        cycle(); idle(); reset_n = 0;
        chk("rst_border", border, 0);
        chk("rst_vector", vector, 0);
        chk("rst_irq", irq, 0);
        timer_latency("rst_timer_latency");

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int sel;
            reset_n = ($urandom_range(0, 299) == 0);
            sel = $urandom_range(0, 5);
            address = 16'($urandom());
            case (sel)
                0: address[7:0] = 8'h00;
                1: address[7:0] = 8'h01;
                2: address[7:0] = 8'h02;
                3: address[7:0] = 8'hFE;
                default: ;
            endcase
            out     = 8'($urandom());
            port_rd = ($urandom_range(0, 2) == 0);
            port_we = ($urandom_range(0, 3) == 0);
            kdone   = ($urandom_range(0, 6) == 0);
            kdata   = 8'($urandom());
            if ($urandom_range(0, 4) == 0) iff1 = ~iff1;
            cycle();
        end
        idle(); reset_n = 0;
        cycle();
        repeat (3) @(negedge clock);
        chk("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
